item_mem_arbiter: RTL

ITEM_MEM_ARBITER -- requirements
Module: item_mem_arbiter

---
 rtl/item_mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/item_mem_arbiter.sv
// Item-memory arbiter: serializes configuration and vend transactions onto one
// single-port item memory and does the stock/sold bookkeeping for vends.
module item_mem_arbiter #(
    parameter int MAX_ITEMS = 1024,
    localparam int AW = $clog2(MAX_ITEMS)
) (
    input  logic          pclk,
    input  logic          prstn,
    input  logic          cfg_mode,
    input  logic [AW:0]   active_items,
    input  logic          cfg_req,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic          cfg_ack,
    output logic [31:0]   cfg_rdata,
    input  logic          vend_req,
    input  logic [AW-1:0] vend_idx,
    output logic          vend_ack,
    output logic [1:0]    vend_status,
    output logic [15:0]   vend_price,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACCESS, CHECK, WB, DONE} state_t;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_EMPTY  = 2'b01;
    localparam logic [1:0] ST_BADIDX = 2'b10;

    state_t      state;
    logic        last_grant_cfg;
    logic        cur_cfg;
    logic        cur_we;
    logic [15:0] held_price;

    logic        grant_cfg;
    logic        grant_vend;
    logic        vend_bad;
    logic [15:0] rd_price;
    logic [7:0]  rd_stock;
    logic [7:0]  rd_sold;
    logic [7:0]  sold_next;
    logic [31:0] wb_word;

    // On a tie in round-robin mode the port that did not win last time goes first.
    always_comb begin
        grant_cfg  = cfg_req && (cfg_mode || !vend_req || !last_grant_cfg);
        grant_vend = vend_req && !grant_cfg;
        vend_bad   = ({1'b0, vend_idx} >= active_items);
    end

    always_comb begin
        rd_price  = mem_rdata[15:0];
        rd_stock  = mem_rdata[23:16];
        rd_sold   = mem_rdata[31:24];
        sold_next = (rd_sold == 8'hFF) ? 8'hFF : rd_sold + 8'd1;
        wb_word   = {sold_next, rd_stock - 8'd1, rd_price};
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state          <= IDLE;
            last_grant_cfg <= 1'b0;
            cur_cfg        <= 1'b0;
            cur_we         <= 1'b0;
            held_price     <= '0;
            cfg_ack        <= 1'b0;
            cfg_rdata      <= '0;
            vend_ack       <= 1'b0;
            vend_status    <= '0;
            vend_price     <= '0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cfg) begin
                        last_grant_cfg <= 1'b1;
                        cur_cfg        <= 1'b1;
                        cur_we         <= cfg_we;
                        mem_en         <= 1'b1;
                        mem_we         <= cfg_we;
                        mem_addr       <= cfg_addr;
                        mem_wdata      <= cfg_wdata;
                        state          <= ACCESS;
                    end else if (grant_vend) begin
                        last_grant_cfg <= 1'b0;
                        cur_cfg        <= 1'b0;
                        cur_we         <= 1'b0;
                        // Out-of-range slots are rejected without touching memory.
                        if (vend_bad) begin
                            vend_ack    <= 1'b1;
                            vend_status <= ST_BADIDX;
                            vend_price  <= '0;
                            state       <= DONE;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= vend_idx;
                            mem_wdata <= cfg_wdata;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (cur_cfg && cur_we) begin
                        cfg_ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (cur_cfg) begin
                        cfg_rdata <= mem_rdata;
                        cfg_ack   <= 1'b1;
                        state     <= DONE;
                    end else if (rd_stock == 8'd0) begin
                        vend_ack    <= 1'b1;
                        vend_status <= ST_EMPTY;
                        vend_price  <= rd_price;
                        state       <= DONE;
                    end else begin
                        // Write back the decremented stock to the same slot.
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_wdata  <= wb_word;
                        held_price <= rd_price;
                        state      <= WB;
                    end
                end
                WB: begin
                    mem_en      <= 1'b0;
                    mem_we      <= 1'b0;
                    vend_ack    <= 1'b1;
                    vend_status <= ST_OK;
                    vend_price  <= held_price;
                    state       <= DONE;
                end
                DONE: begin
                    cfg_ack  <= 1'b0;
                    vend_ack <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    cfg_ack  <= 1'b0;
                    vend_ack <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
